// File: rtl/dma_addr_gen_pkg.sv
// dma_addr_gen_pkg: mode codes and FSM states shared by the DMA address generator
package dma_addr_gen_pkg;
  typedef enum logic [1:0] {MODE_WC_DOWN = 2'b00, MODE_WC_UP = 2'b01, MODE_ADDR_CMP = 2'b10, MODE_FREE = 2'b11} mode_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/dma_addr_gen_if.sv
// dma_addr_gen_if: control/status bus of the DMA address generator
interface dma_addr_gen_if import dma_addr_gen_pkg::*; #(parameter int AW = 16, parameter int WCW = 16);
  logic [AW-1:0] data_in;
  logic load_addr, load_wc, dir, start, reinit, step, aci;
  mode_t mode;
  logic [AW-1:0] addr_out;
  logic [WCW-1:0] wc_out;
  logic aco, busy, done;
  modport master(output data_in, load_addr, load_wc, mode, dir, start, reinit, step, aci,
                 input addr_out, wc_out, aco, busy, done);
  modport slave(input data_in, load_addr, load_wc, mode, dir, start, reinit, step, aci,
                output addr_out, wc_out, aco, busy, done);
endinterface

// File: rtl/dma_addr_gen_updown_counter.sv
// dma_updown_counter: loadable up/down counter with terminal-count flag for the next step direction
module dma_updown_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] q,
  output logic         tc
);
  assign tc = up ? &q : ~|q;
  always_ff @(posedge clk) begin
    if (res) q <= '0;
    else if (load) q <= data;
    else if (en) q <= up ? q + 1'b1 : q - 1'b1;
  end
endmodule

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: DMA address/word-count generator with termination modes; AUTO_REINIT_EN selects circular-buffer reload
module dma_addr_gen import dma_addr_gen_pkg::*; #(parameter int AW = 16, parameter int WCW = 16) (
  input logic clk,
  input logic res,
  dma_addr_gen_if.slave bus
);
  logic [AW-1:0] addr_reg, addr_q, addr_nx;
  logic [WCW-1:0] wc_reg, wc_q;
  logic addr_tc, wc_tc, any_load, rein, acc, term, reload, pulse_q;
  state_t state, state_nx;
  mode_t mode_q;
  assign any_load = bus.load_addr | bus.load_wc;
  assign rein = bus.reinit & ~any_load;
  assign acc = (state == S_RUN) & bus.step & bus.aci & ~any_load & ~bus.reinit;
  assign addr_nx = bus.dir ? addr_q + 1'b1 : addr_q - 1'b1;
  assign term = mode_q == MODE_WC_DOWN  ? wc_q == WCW'(1) :
                mode_q == MODE_WC_UP    ? wc_tc :
                mode_q == MODE_ADDR_CMP ? addr_nx == AW'(wc_reg) : 1'b0;
`ifdef AUTO_REINIT_EN
  assign reload = acc & term;
`else
  assign reload = 1'b0;
`endif
  dma_updown_counter #(.W(AW)) u_addr (
    .clk(clk), .res(res),
    .load(bus.load_addr | rein | reload),
    .data(bus.load_addr ? bus.data_in : addr_reg),
    .en(acc), .up(bus.dir), .q(addr_q), .tc(addr_tc)
  );
  dma_updown_counter #(.W(WCW)) u_wc (
    .clk(clk), .res(res),
    .load(bus.load_wc | rein | reload),
    .data(bus.load_wc ? bus.data_in[WCW-1:0] : wc_reg),
    .en(acc & (mode_q == MODE_WC_DOWN || mode_q == MODE_WC_UP)),
    .up(mode_q == MODE_WC_UP), .q(wc_q), .tc(wc_tc)
  );
  always_comb begin
    state_nx = (any_load | bus.reinit)          ? S_IDLE :
               (state == S_IDLE && bus.start)   ? S_RUN  :
               (acc && term && !reload)         ? S_DONE : state;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state <= S_IDLE;
      mode_q <= MODE_WC_DOWN;
      addr_reg <= '0;
      wc_reg <= '0;
      pulse_q <= 1'b0;
    end else begin
      state <= state_nx;
      pulse_q <= reload;
      if (state == S_IDLE && bus.start && !any_load && !bus.reinit) mode_q <= bus.mode;
      if (bus.load_addr) addr_reg <= bus.data_in;
      if (bus.load_wc) wc_reg <= bus.data_in[WCW-1:0];
    end
  end
  assign bus.addr_out = addr_q;
  assign bus.wc_out = wc_q;
  assign bus.busy = state == S_RUN;
  assign bus.done = (state == S_DONE) | pulse_q;
  assign bus.aco = bus.busy & bus.step & bus.aci & addr_tc;
endmodule

// File: tb/tb_dma_addr_gen.sv
// tb_dma_addr_gen: directed table-driven check of dma_addr_gen (build-aware of AUTO_REINIT_EN)
module tb_dma_addr_gen;
  import dma_addr_gen_pkg::*;
  typedef struct {
    logic [6:0]  c;
    logic [1:0]  m;
    logic [15:0] d;
    logic [15:0] ea;
    logic [15:0] ew;
    logic [2:0]  e;
  } vec_t;
  logic clk = 1'b0;
  logic res;
  int total = 0;
  int bad = 0;
  vec_t tv[$];
  dma_addr_gen_if #(.AW(16), .WCW(16)) bus();
  dma_addr_gen #(.AW(16), .WCW(16)) dut (.clk(clk), .res(res), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [6:0] c, input logic [1:0] m, input logic [15:0] d,
                             input logic [15:0] ea, input logic [15:0] ew, input logic [2:0] e);
    vec_t r;
    r.c = c; r.m = m; r.d = d; r.ea = ea; r.ew = ew; r.e = e;
    return r;
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [6:0] c, input logic [1:0] m, input logic [15:0] d);
    {bus.load_addr, bus.load_wc, bus.reinit, bus.start, bus.step, bus.aci, bus.dir} = c;
    bus.mode = mode_t'(m);
    bus.data_in = d;
  endtask
  task automatic check_state(input string tag, input logic [15:0] ea, input logic [15:0] ew, input logic eb, input logic ed);
    chk($sformatf("%s addr", tag), bus.addr_out, ea);
    chk($sformatf("%s wc", tag), bus.wc_out, ew);
    chk($sformatf("%s busy", tag), 16'(bus.busy), 16'(eb));
    chk($sformatf("%s done", tag), 16'(bus.done), 16'(ed));
  endtask
  task automatic run_vec(input int i, input vec_t t);
    @(negedge clk);
    drive(t.c, t.m, t.d);
    #1 chk($sformatf("v%0d aco", i), 16'(bus.aco), 16'(t.e[0]));
    @(posedge clk);
    #1 check_state($sformatf("v%0d", i), t.ea, t.ew, t.e[2], t.e[1]);
  endtask
  initial begin
    // control bits: {load_addr, load_wc, reinit, start, step, aci, dir}; expect bits: {busy, done, aco}
`ifndef AUTO_REINIT_EN
    tv.push_back(v(7'b1000001, 2'd0, 16'h0100, 16'h0100, 16'h0000, 3'b000));
    tv.push_back(v(7'b0100001, 2'd0, 16'h0003, 16'h0100, 16'h0003, 3'b000));
    tv.push_back(v(7'b0001001, 2'd0, 16'h0000, 16'h0100, 16'h0003, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0101, 16'h0002, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0102, 16'h0001, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0103, 16'h0000, 3'b010));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0103, 16'h0000, 3'b010));
    tv.push_back(v(7'b0010001, 2'd0, 16'h0000, 16'h0100, 16'h0003, 3'b000));
    tv.push_back(v(7'b1000001, 2'd0, 16'hFFFE, 16'hFFFE, 16'h0003, 3'b000));
    tv.push_back(v(7'b0001001, 2'd3, 16'h0000, 16'hFFFE, 16'h0003, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'hFFFF, 16'h0003, 3'b100));
    tv.push_back(v(7'b0000101, 2'd0, 16'h0000, 16'hFFFF, 16'h0003, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0000, 16'h0003, 3'b101));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0001, 16'h0003, 3'b100));
    tv.push_back(v(7'b1000111, 2'd0, 16'h0200, 16'h0200, 16'h0003, 3'b000));
    tv.push_back(v(7'b1000001, 2'd0, 16'h0010, 16'h0010, 16'h0003, 3'b000));
    tv.push_back(v(7'b0100001, 2'd0, 16'h0014, 16'h0010, 16'h0014, 3'b000));
    tv.push_back(v(7'b0001001, 2'd2, 16'h0000, 16'h0010, 16'h0014, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0011, 16'h0014, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0012, 16'h0014, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0013, 16'h0014, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0014, 16'h0014, 3'b010));
    tv.push_back(v(7'b0010001, 2'd0, 16'h0000, 16'h0010, 16'h0014, 3'b000));
    tv.push_back(v(7'b0100001, 2'd0, 16'hFFFE, 16'h0010, 16'hFFFE, 3'b000));
    tv.push_back(v(7'b0001000, 2'd1, 16'h0000, 16'h0010, 16'hFFFE, 3'b100));
    tv.push_back(v(7'b0000110, 2'd0, 16'h0000, 16'h000F, 16'hFFFF, 3'b100));
    tv.push_back(v(7'b0000110, 2'd0, 16'h0000, 16'h000E, 16'h0000, 3'b010));
`else
    tv.push_back(v(7'b1000001, 2'd0, 16'h0100, 16'h0100, 16'h0000, 3'b000));
    tv.push_back(v(7'b0100001, 2'd0, 16'h0002, 16'h0100, 16'h0002, 3'b000));
    tv.push_back(v(7'b0001001, 2'd0, 16'h0000, 16'h0100, 16'h0002, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0101, 16'h0001, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0100, 16'h0002, 3'b110));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0101, 16'h0001, 3'b100));
    tv.push_back(v(7'b0000111, 2'd0, 16'h0000, 16'h0100, 16'h0002, 3'b110));
    tv.push_back(v(7'b0000001, 2'd0, 16'h0000, 16'h0100, 16'h0002, 3'b100));
`endif
    res = 1'b1;
    drive(7'b1001001, 2'd0, 16'h1234);
    repeat (2) @(posedge clk);
    #1 check_state("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    res = 1'b0;
    drive(7'b0000001, 2'd0, 16'h0000);
    for (int i = 0; i < tv.size(); i++) run_vec(i, tv[i]);
`ifndef AUTO_REINIT_EN
    repeat (3) run_vec(100, v(7'b0000111, 2'd0, 16'h0000, 16'h000E, 16'h0000, 3'b010));
    run_vec(101, v(7'b1000001, 2'd0, 16'h0050, 16'h0050, 16'h0000, 3'b000));
    run_vec(102, v(7'b0001001, 2'd3, 16'h0000, 16'h0050, 16'h0000, 3'b100));
    run_vec(103, v(7'b0001111, 2'd0, 16'h0000, 16'h0051, 16'h0000, 3'b100));
`else
    run_vec(101, v(7'b1000001, 2'd0, 16'h0050, 16'h0050, 16'h0002, 3'b000));
    run_vec(102, v(7'b0001001, 2'd3, 16'h0000, 16'h0050, 16'h0002, 3'b100));
    run_vec(103, v(7'b0001111, 2'd0, 16'h0000, 16'h0051, 16'h0002, 3'b100));
`endif
    @(negedge clk);
    res = 1'b1;
    drive(7'b0000111, 2'd0, 16'h0000);
    @(posedge clk);
    #1 check_state("midrun_reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    res = 1'b0;
    drive(7'b0000001, 2'd0, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
